// File: rtl/shift_sequencer.sv
// Multicycle shifter: applies one fixed power-of-two stage per cycle, MSB-first.
// Define SHIFT_SEQ_ROTATE_EN to make op 2'b11 a rotate-right; otherwise op 2'b11 is a no-op.
module shift_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [WIDTH-1:0]   data_operand,
  input  logic [SHAMT_W-1:0] data_shamt,
  input  logic [1:0]         ctrl_op,
  output logic               busy,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_resultRDY
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRot = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] mask_q, mask_d;
  logic [1:0]         op_q, op_d;

  logic [SHAMT_W-1:0] top_oh;
  logic [SHAMT_W-1:0] mask_rem;
  logic [WIDTH-1:0]   stage_out;
  logic               start_noop;

  // One stage of the shift path; k is a loop constant at every call site.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] v,
                                                    input logic [1:0]       op,
                                                    input int unsigned      k);
    int unsigned s;
    logic [WIDTH-1:0] r;
    s = 32'd1 << k;
    case (op)
      OpSll:   r = v << s;
      OpSrl:   r = v >> s;
      OpSra:   r = $signed(v) >>> s;
`ifdef SHIFT_SEQ_ROTATE_EN
      OpRot:   r = (v >> s) | (v << (WIDTH - s));
`else
      OpRot:   r = v;
`endif
      default: r = v;
    endcase
    return r;
  endfunction

`ifdef SHIFT_SEQ_ROTATE_EN
  assign start_noop = 1'b0;
`else
  assign start_noop = (ctrl_op == OpRot);
`endif

  // Highest pending stage, as a one-hot.
  always_comb begin
    top_oh = '0;
    for (int unsigned k = 0; k < SHAMT_W; k++) begin
      if (mask_q[k]) begin
        top_oh    = '0;
        top_oh[k] = 1'b1;
      end
    end
  end

  assign mask_rem = mask_q & ~top_oh;

  always_comb begin
    stage_out = work_q;
    for (int unsigned k = 0; k < SHAMT_W; k++) begin
      if (top_oh[k]) begin
        stage_out = shift_stage(work_q, op_q, k);
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      work_q   <= '0;
      result_q <= '0;
      mask_q   <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      mask_q   <= mask_d;
      op_q     <= op_d;
    end
  end

  // Next-state logic; DONE accepts a start exactly like IDLE.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    mask_d   = mask_q;
    op_d     = op_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (ctrl_start) begin
          work_d = data_operand;
          mask_d = data_shamt;
          op_d   = ctrl_op;
          if ((data_shamt == '0) || start_noop) begin
            state_d  = StDone;
            result_d = data_operand;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        work_d = stage_out;
        mask_d = mask_rem;
        if (mask_rem == '0) begin
          state_d  = StDone;
          result_d = stage_out;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy           = (state_q == StShift);
    data_resultRDY = (state_q == StDone);
    data_result    = result_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed plan cases plus randomized ops
// checked against an arithmetic reference model.
module tb_shift_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_operand;
  logic [4:0]  data_shamt;
  logic [1:0]  ctrl_op;
  logic        busy;
  logic [31:0] data_result;
  logic        data_resultRDY;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prev_result;

  shift_sequencer #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_start    (ctrl_start),
    .data_operand  (data_operand),
    .data_shamt    (data_shamt),
    .ctrl_op       (ctrl_op),
    .busy          (busy),
    .data_result   (data_result),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] v, input int n, input logic [1:0] op);
    logic [31:0] r;
    case (op)
      2'd0:    r = v << n;
      2'd1:    r = v >> n;
      2'd2:    r = $signed(v) >>> n;
`ifdef SHIFT_SEQ_ROTATE_EN
      default: r = (v >> n) | (v << (32 - n));
`else
      default: r = v;
`endif
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [4:0] sh, input logic [1:0] op);
`ifdef SHIFT_SEQ_ROTATE_EN
    return $countones(sh) + 1;
`else
    return (op == 2'd3) ? 1 : $countones(sh) + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op at the current cycle and follow it to its RDY cycle (returns in DONE).
  task automatic run_op(input logic [31:0] v, input logic [4:0] sh, input logic [1:0] op,
                        input bit inject);
    int cyc;
    int lat;
    logic [31:0] exp;
    exp          = model(v, int'(sh), op);
    lat          = model_lat(sh, op);
    ctrl_start   = 1'b1;
    data_operand = v;
    data_shamt   = sh;
    ctrl_op      = op;
    tick();
    ctrl_start   = 1'b0;
    data_operand = $urandom;
    data_shamt   = 5'($urandom);
    ctrl_op      = 2'($urandom);
    cyc          = 1;
    while (!data_resultRDY && cyc <= 8) begin
      check("busy_in_flight", {31'd0, busy}, 32'd1);
      check("hold_result", data_result, prev_result);
      if (inject) begin
        ctrl_start   = 1'b1;
        data_operand = $urandom;
        data_shamt   = 5'($urandom_range(0, 31));
        ctrl_op      = 2'($urandom);
      end
      tick();
      ctrl_start = 1'b0;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat));
    check("result", data_result, exp);
    check("busy_at_rdy", {31'd0, busy}, 32'd0);
    prev_result = exp;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_rdy", {31'd0, data_resultRDY}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_hold", data_result, prev_result);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    ctrl_start   = 1'b0;
    data_operand = '0;
    data_shamt   = '0;
    ctrl_op      = '0;
    prev_result  = '0;
    tick();
    tick();
    reset = 1'b0;
    idle_cycles(3);

    run_op(32'h0000_0001, 5'd8, 2'd0, 1'b0);
    check("plan_sll", data_result, 32'h0000_0100);
    idle_cycles(1);
    run_op(32'h8000_0000, 5'd31, 2'd2, 1'b0);
    check("plan_sra", data_result, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 5'd31, 2'd1, 1'b1);
    check("plan_srl", data_result, 32'h0000_0001);
    idle_cycles(2);
    run_op(32'h1234_5678, 5'd0, 2'd1, 1'b0);
    run_op(32'h0000_000F, 5'd4, 2'd0, 1'b0);
    check("plan_b2b", data_result, 32'h0000_00F0);
    idle_cycles(1);
    run_op(32'h0000_00F1, 5'd4, 2'd3, 1'b0);
`ifdef SHIFT_SEQ_ROTATE_EN
    check("plan_op11", data_result, 32'h1000_000F);
`else
    check("plan_op11", data_result, 32'h0000_00F1);
`endif
    idle_cycles(1);

    // Reset in the middle of a long shift aborts it.
    ctrl_start   = 1'b1;
    data_operand = 32'hDEAD_BEEF;
    data_shamt   = 5'd31;
    ctrl_op      = 2'd0;
    tick();
    ctrl_start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    prev_result = '0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("abort_result", data_result, 32'd0);
    idle_cycles(6);

    // Reset beats a simultaneous start.
    run_op(32'hCAFE_F00D, 5'd0, 2'd0, 1'b0);
    tick();
    reset        = 1'b1;
    ctrl_start   = 1'b1;
    data_operand = 32'h5555_AAAA;
    data_shamt   = 5'd0;
    tick();
    reset       = 1'b0;
    ctrl_start  = 1'b0;
    prev_result = '0;
    check("rst_start_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("rst_start_result", data_result, 32'd0);
    idle_cycles(2);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] sh;
      sh = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_op($urandom, sh, 2'($urandom), bit'($urandom_range(0, 3) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle shift unit controller for the ALU shift path.
- Drives fixed power-of-two shift stages (16/8/4/2/1) one stage per cycle: latches the operand and shift amount, then applies the largest pending stage each cycle until the amount is consumed.
- Sits beside the ALU; the pipeline stalls on busy, the same way it stalls for multdiv.
- Trades shifter area for latency of popcount(shamt)+1 cycles.

Parameters:
- WIDTH, 32, data width; must be a power of two.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- ctrl_start  in  1  start request; sampled only while busy=0.
- data_operand  in  WIDTH  value to shift; latched on accepted start.
- data_shamt  in  SHAMT_W  shift amount; latched on accepted start.
- ctrl_op  in  2  op code: 00 SLL, 01 SRL, 10 SRA, 11 see Optional Feature.
- busy  out  1  high while an operation is in flight.
- data_result  out  WIDTH  shift result; holds the last value until the next accepted start completes.
- data_resultRDY  out  1  one-cycle pulse when data_result is valid.

Behaviour:
- Reset is synchronous, active-high. At reset: state=IDLE; busy=0, data_resultRDY=0, data_result=0; internal mask and op registers = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On ctrl_start=1: latch operand into the work register, shamt into the pending mask, and ctrl_op.
  - Go to DONE if the mask is 0 or the op is a no-op (see Optional Feature); otherwise go to SHIFT.
- SHIFT:
  - Each cycle, pick the highest set mask bit k and apply a shift of 2^k to the work register.
  - Clear bit k. If the remaining mask is 0, go to DONE.
  - Stage order is MSB-first, so shift counts are 16, 8, 4, 2, 1.
- Shift fill rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: MSB-fill with the latched operand's bit [WIDTH-1].
- DONE:
  - data_result = work register; data_resultRDY=1 for exactly this cycle; busy=0.
  - Next state is IDLE.
  - A ctrl_start present in the DONE cycle is accepted, with the same transitions as IDLE, giving back-to-back operation.
- busy:
  - 1 in SHIFT.
  - 0 in IDLE and DONE.
  - Also 1 in the cycle immediately after an accepted start that enters SHIFT.
- Latency: data_resultRDY is asserted popcount(shamt)+1 cycles after the edge that accepted the start.
  - Minimum 1 cycle (shamt=0).
  - Maximum SHAMT_W+1 cycles (shamt=31 → 6).
- ctrl_start while busy=1 is ignored; no queuing.
- Inputs are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- Reset asserted mid-SHIFT: the operation is aborted, no RDY pulse, data_result=0 on the next cycle.
- Reset and ctrl_start in the same cycle: reset wins, and the start is dropped.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: ctrl_op=11 is ROR (rotate right). Each stage rotates right by 2^k; bits leaving the LSB re-enter at the MSB. Latency follows the normal rule.
- Undefined: ctrl_op=11 is a no-op. The IDLE→DONE path is taken regardless of shamt, data_result = data_operand, and latency is 1.

Test Plan:
- Reset, then idle 3 cycles → busy=0, data_resultRDY=0, data_result=0.
- start, operand=0x0000_0001, shamt=8, op=SLL → RDY pulse 2 cycles after the start edge; data_result=0x0000_0100.
- start, operand=0x8000_0000, shamt=31, op=SRA → busy for 5 cycles, RDY at cycle 6, data_result=0xFFFF_FFFF. Same stimulus with op=SRL → data_result=0x0000_0001.
- start, shamt=0, operand=0x1234_5678, op=SRL → RDY at cycle 1, data_result=0x1234_5678. Assert a second start (operand=0xF, shamt=4, op=SLL) in the RDY cycle → accepted; second RDY 2 cycles later with 0xF0.
- During busy, pulse ctrl_start with different data → ignored; the first result is unchanged. Assert reset during SHIFT → no RDY pulse, busy=0, data_result=0 next cycle.
- op=11, operand=0x0000_00F1, shamt=4:
  - With SHIFT_SEQ_ROTATE_EN: data_result=0x1000_000F, RDY at cycle 2.
  - Without it: data_result=0x0000_00F1, RDY at cycle 1.
